// File: rtl/fetch_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_pkg : shared encodings and constants for the instruction fetch unit
// Revision  : 1.0 - initial release
// ---------------------------------------------------------------------------
package fetch_pkg;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  typedef enum logic [0:0] {
    S_RUN  = ST_RUN,
    S_HALT = ST_HALT
  } state_e;

  localparam int unsigned PC_INC     = 4;
  localparam logic [1:0]  ALIGN_MASK = 2'b11;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_queue : registered FIFO with flush; head is visible the cycle after push
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module fetch_queue #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  logic [WIDTH-1:0]             data_i,
  output logic [WIDTH-1:0]             data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             w_do_push;
  logic             w_do_pop;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign data_o    = mem_q[rd_ptr_q];
  assign w_do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign w_do_push = push_i && (!full_o || w_do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (w_do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_q + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_sequencer : PC owner and IF-stage sequencer with redirect and fault trap
// Revision        : 1.0 - initial release
// ---------------------------------------------------------------------------
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned       PC_W      = 32,
  parameter int unsigned       INST_W    = 32,
  parameter int unsigned       MEM_WORDS = 64,
  parameter int unsigned       DEPTH     = 2,
  parameter logic [PC_W-1:0]   RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_data,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   inst_pc,
  input  logic              inst_ready,
  output logic              fault
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned ENT_W = INST_W + PC_W;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              w_push;
  logic              w_flush;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_room;
  logic              w_in_range;
  logic              w_aligned;
  logic [CNT_W-1:0]  w_count;
  logic [ENT_W-1:0]  w_head;

  assign imem_addr  = pc_q >> 2;
  assign w_in_range = (imem_addr < PC_W'(MEM_WORDS));
  assign w_aligned  = ((redirect_pc[1:0] & ALIGN_MASK) == 2'b00);
  assign w_pop      = inst_valid && inst_ready;
  assign w_room     = (w_count < CNT_W'(DEPTH)) || w_pop;

  // Redirect outranks fetch; a misaligned target traps without touching pc.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    w_push  = 1'b0;
    w_flush = 1'b0;
    case (state_q)
      S_RUN: begin
        if (redirect_valid) begin
          w_flush = 1'b1;
          if (w_aligned) begin
            pc_d = redirect_pc;
          end else begin
            state_d = S_HALT;
          end
        end else if (en) begin
          if (!w_in_range) begin
            state_d = S_HALT;
          end else if (w_room) begin
            w_push = 1'b1;
            pc_d   = pc_q + PC_W'(PC_INC);
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_queue #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .flush_i (w_flush),
    .data_i  ({imem_data, pc_q}),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  assign inst_valid = !w_empty;
  assign inst       = w_head[ENT_W-1 -: INST_W];
  assign inst_pc    = w_head[PC_W-1:0];
  assign fault      = (state_q == S_HALT);

  a_full_matches_count: assert property (@(posedge clk) disable iff (reset)
    w_full == (w_count == CNT_W'(DEPTH)));

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fetch_sequencer : directed stimulus with a queue-based delivery scoreboard
// Revision           : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        fault;

  int vectors     = 0;
  int miscompares = 0;

  // Expected deliveries, packed as {inst, inst_pc}.
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  // Memory word k holds the value k.
  assign imem_data = imem_addr;

  fetch_sequencer #(
    .PC_W      (32),
    .INST_W    (32),
    .MEM_WORDS (64),
    .DEPTH     (2),
    .RESET_PC  (32'h0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .en             (en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .fault          (fault)
  );

  always @(negedge clk) begin : monitor
    logic [63:0] e;
    if (!reset && inst_valid && inst_ready) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_delivery: got inst=%0h pc=%0h, required no delivery", inst, inst_pc);
      end else begin
        e = sb.pop_front();
        if (inst !== e[63:32] || inst_pc !== e[31:0]) begin
          miscompares++;
          $display("FAIL delivery: got inst=%0h pc=%0h, required inst=%0h pc=%0h",
                   inst, inst_pc, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic expect_word(input int k);
    sb.push_back({32'(k), 32'(4 * k)});
  endtask

  // Leaves the bench in cycle 0 with reset just deasserted.
  task automatic do_reset();
    chk("scoreboard_empty_before_reset", sb.size(), 0);
    sb.delete();
    reset = 1'b1; en = 1'b0; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    cyc();
    cyc();
    chk("reset_inst_valid", inst_valid, 0);
    chk("reset_inst", inst, 0);
    chk("reset_inst_pc", inst_pc, 0);
    chk("reset_fault", fault, 0);
    chk("reset_imem_addr", imem_addr, 0);
    reset = 1'b0;
  endtask

  initial begin
    // Streaming from reset.
    do_reset();
    en = 1'b1; inst_ready = 1'b1;
    for (int k = 0; k < 10; k++) expect_word(k);
    chk("stream_c0_valid", inst_valid, 0);
    for (int c = 1; c <= 10; c++) begin
      cyc();
      if (c == 10) en = 1'b0;
      chk("stream_valid", inst_valid, 1);
      if (c == 1) chk("stream_first_inst", inst, 0);
    end
    cyc();
    chk("stream_drained", inst_valid, 0);
    chk("stream_pc", imem_addr, 10);

    // Backpressure: two entries buffered, pc holds at 8.
    do_reset();
    en = 1'b1; inst_ready = 1'b0;
    for (int k = 0; k < 8; k++) expect_word(k);
    repeat (5) cyc();
    chk("bp_pc_hold", imem_addr, 2);
    chk("bp_head_pc", inst_pc, 0);
    chk("bp_valid", inst_valid, 1);
    inst_ready = 1'b1;
    for (int c = 5; c <= 12; c++) begin
      chk("bp_no_gap", inst_valid, 1);
      cyc();
      if (c + 1 == 11) en = 1'b0;
    end
    chk("bp_drained", inst_valid, 0);

    // Redirect with a full queue; the head popped that cycle is consumed.
    do_reset();
    en = 1'b1; inst_ready = 1'b0;
    cyc();
    cyc();
    expect_word(0);
    for (int k = 16; k < 19; k++) expect_word(k);
    redirect_valid = 1'b1; redirect_pc = 32'h40; inst_ready = 1'b1;
    cyc();
    redirect_valid = 1'b0;
    chk("rd_gap_valid", inst_valid, 0);
    chk("rd_target_addr", imem_addr, 16);
    cyc();
    chk("rd_valid", inst_valid, 1);
    chk("rd_inst_pc", inst_pc, 32'h40);
    chk("rd_inst", inst, 16);
    cyc();
    cyc();
    en = 1'b0;
    cyc();
    cyc();
    chk("rd_drained", inst_valid, 0);
    chk("rd_pc_end", imem_addr, 19);

    // Misaligned redirect traps; later redirects ignored.
    do_reset();
    en = 1'b1; inst_ready = 1'b1;
    expect_word(0);
    expect_word(1);
    cyc();
    cyc();
    chk("mis_fault_pre", fault, 0);
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    cyc();
    chk("mis_fault", fault, 1);
    chk("mis_valid", inst_valid, 0);
    chk("mis_pc_hold", imem_addr, 2);
    redirect_pc = 32'h80;
    cyc();
    redirect_valid = 1'b0;
    chk("mis_redirect_ignored", imem_addr, 2);
    chk("mis_fault_sticky", fault, 1);
    repeat (3) cyc();
    chk("mis_no_fetch", inst_valid, 0);

    // Range limit at word 63, with a stall so the queue drains after the fault.
    do_reset();
    en = 1'b1; inst_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'hF0;
    for (int k = 60; k < 64; k++) expect_word(k);
    cyc();
    redirect_valid = 1'b0;
    cyc();
    cyc();
    inst_ready = 1'b0;
    cyc();
    cyc();
    chk("rng_pc_hold", imem_addr, 63);
    chk("rng_fault_pre", fault, 0);
    cyc();
    inst_ready = 1'b1;
    cyc();
    chk("rng_fault_lag", fault, 0);
    chk("rng_addr_wrap", imem_addr, 64);
    cyc();
    chk("rng_fault", fault, 1);
    chk("rng_drain_valid", inst_valid, 1);
    chk("rng_last_inst", inst, 63);
    chk("rng_addr_hold", imem_addr, 64);
    cyc();
    chk("rng_empty", inst_valid, 0);
    repeat (3) cyc();
    chk("rng_no_fetch", inst_valid, 0);

    // Reset mid-stream with two entries queued.
    do_reset();
    en = 1'b1; inst_ready = 1'b0;
    cyc();
    cyc();
    chk("mid_pre_valid", inst_valid, 1);
    reset = 1'b1;
    cyc();
    chk("mid_valid", inst_valid, 0);
    chk("mid_addr", imem_addr, 0);
    reset = 1'b0; en = 1'b1; inst_ready = 1'b1;
    for (int k = 0; k < 3; k++) expect_word(k);
    cyc();
    cyc();
    cyc();
    en = 1'b0;
    cyc();
    cyc();
    chk("mid_drained", inst_valid, 0);

    chk("scoreboard_empty_at_end", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
